// File: rtl/regfile_wbuf_if.sv
// Write-back and decode-side bus of the buffered register file.
// master drives the write and read requests; slave is the register file.
interface regfile_wbuf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     overflow;
  logic                     flush;
  logic [ADDR_W-1:0]        raddr1;
  logic [ADDR_W-1:0]        raddr2;
  logic [DATA_W-1:0]        rdata1;
  logic [DATA_W-1:0]        rdata2;
  logic                     pend_valid;
  logic [(1<<ADDR_W)-1:0]   wr_onehot;

  modport master (
    output we, waddr, wdata, overflow, flush, raddr1, raddr2,
    input  rdata1, rdata2, pend_valid, wr_onehot
  );

  modport slave (
    input  we, waddr, wdata, overflow, flush, raddr1, raddr2,
    output rdata1, rdata2, pend_valid, wr_onehot
  );
endinterface

// File: rtl/regfile_wbuf.sv
// Register file with a one-entry registered write buffer, overflow/flush
// cancellation, optional hardwired zero register and read bypass.
module regfile_wbuf #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_wbuf_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [DEPTH-1:0]  onehot_q;

  logic              capture_d;
  logic [DEPTH-1:0]  onehot_d;

  always_comb begin
    capture_d = bus.we && !bus.overflow &&
                !((ZERO_REG != 0) && (bus.waddr == '0));
    onehot_d  = capture_d ? (ONE << bus.waddr) : '0;
  end

  // Commit of the held entry and capture of the new one share an edge,
  // so back-to-back writes stream without a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      onehot_q     <= '0;
    end else begin
      if (pend_valid_q && !bus.flush) begin
        for (int i = 0; i < DEPTH; i++)
          if (onehot_q[i]) mem_q[i] <= pend_data_q;
      end
      pend_valid_q <= capture_d;
      onehot_q     <= onehot_d;
      if (capture_d) begin
        pend_addr_q <= bus.waddr;
        pend_data_q <= bus.wdata;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if ((ZERO_REG != 0) && (a == '0))
      return '0;
    // A flushed entry must not leak through the bypass path.
    if ((BYPASS != 0) && pend_valid_q && !bus.flush && (pend_addr_q == a))
      return pend_data_q;
    return mem_q[a];
  endfunction

  always_comb begin
    bus.rdata1     = rd(bus.raddr1);
    bus.rdata2     = rd(bus.raddr2);
    bus.pend_valid = pend_valid_q;
    bus.wr_onehot  = onehot_q;
  end
endmodule
